m_clint: RTL and testbench
==========================

M_CLINT -- requirements
Module: m_clint

Interface
REQ-001 Parameter N_HARTS, default 1: number of harts served, 1..8.
REQ-002 Parameter TICK_DIV, default 1: CLK cycles per mtime increment, >=1.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST_X  in  1  reset, asynchronous, active-low.
REQ-005 w_time_en  in  1  1 = mtime and prescaler advance; 0 = both frozen.
REQ-006 w_we  in  1  register write strobe, one cycle per access.
REQ-007 w_re  in  1  register read strobe, one cycle per access.
REQ-008 w_addr  in  16  byte offset in the CLINT window; bits [1:0] ignored.
REQ-009 w_wdata  in  32  write data.
REQ-010 w_rdata  out  32  read data, valid while w_rvalid=1.
REQ-011 w_rvalid  out  1  read-response pulse.
REQ-012 w_mtime  out  64  current mtime; feeds the core cluster's w_mtime.
REQ-013 w_mtip  out  N_HARTS  per-hart machine timer interrupt pending; feeds the cluster's w_mtip.
REQ-014 w_msip  out  N_HARTS  per-hart machine software interrupt pending; feeds the cluster's w_msip.

Function
REQ-015 Address map: msip[h] at 0x0000+4h, with bit0 only; mtimecmp[h] low/high at 0x4000+8h / 0x4004+8h; mtime low/high at 0xBFF8 / 0xBFFC.
REQ-016 Hart index h >= N_HARTS, and any unlisted offset, reads as 0; writes to these offsets have no effect.
REQ-017 A write updates the target register at the edge where w_we=1; msip writes store only w_wdata[0].
REQ-018 A read captures the addressed value at the edge where w_re=1; w_rdata/w_rvalid are presented the next cycle for exactly one cycle; latency is 1.
REQ-019 w_we and w_re asserted together: the write is performed, and the read returns the pre-write value.
REQ-020 Prescaler: counter runs 0..TICK_DIV-1 while w_time_en=1; mtime increments by 1 (64-bit) in the cycle the counter equals TICK_DIV-1, and the counter returns to 0.
REQ-021 When TICK_DIV=1, mtime increments every cycle w_time_en=1.
REQ-022 mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0, with carry from the low word into the high word within the same cycle.
REQ-023 A software write to either mtime half in the same cycle as an increment wins for that half; the other half keeps its incremented value, including carry; the prescaler is unaffected.
REQ-024 w_mtip[h] is registered: it equals (mtime >= mtimecmp[h], 64-bit unsigned) evaluated on the previous cycle's register values; the compare is level-based and clears when mtimecmp is raised.
REQ-025 w_msip[h] equals stored msip[h] bit directly from its register.
REQ-026 w_time_en=0: mtime and the prescaler hold their values; register access and mtip evaluation continue.
REQ-027 The block has no backpressure; it accepts one access per cycle.

Reset
REQ-028 While RST_X=0, regardless of clock: mtime=0, prescaler=0, mtimecmp[all]=0xFFFF_FFFF_FFFF_FFFF, msip[all]=0, w_mtip=0, w_msip=0, w_rvalid=0, w_rdata=0.
REQ-029 Reset asserted mid-read cancels the pending w_rvalid pulse.
REQ-030 Leaving reset, mtime starts counting after the first rising edge with RST_X=1 and w_time_en=1.

Verification
REQ-031 TICK_DIV=4, w_time_en=1 for 40 cycles after reset -> w_mtime=10; w_time_en=0 for 20 more cycles -> w_mtime stays 10.
REQ-032 N_HARTS=2: write 0x4008=5 and 0x400C=0; run TICK_DIV=1 -> w_mtip[1] rises the cycle after mtime reaches 5, and w_mtip[0] stays 0; then write 0x400C=1 -> w_mtip[1] falls next cycle.
REQ-033 Write 0xBFF8=0xFFFF_FFFF and 0xBFFC=0; one increment -> read 0xBFFC returns 1 and 0xBFF8 returns 0, each with w_rvalid one cycle after w_re.
REQ-034 Write 0x0004=0x3 with N_HARTS=2 -> w_msip=2'b10; read 0x0004 -> 1; read 0x0008 or 0x1234 -> 0; write 0x0008 -> no state change.
REQ-035 Same-cycle w_we and w_re to 0x0000 with wdata=1 from msip=0 -> w_rdata=0 next cycle and w_msip[0]=1.
REQ-036 Assert RST_X=0 between edges during a pending read with mtime=100 -> w_rvalid, w_mtime, w_msip, and w_mtip go to 0 immediately.

Source files
------------

// File: rtl/m_clint_if.sv
// Register-access bus of the core-local interruptor: one-cycle read/write strobes
// with a registered read response one cycle after the read strobe.
interface m_clint_if;
  logic        w_we;
  logic        w_re;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_rvalid;

  modport master (output w_we, w_re, w_addr, w_wdata, input w_rdata, w_rvalid);
  modport slave  (input w_we, w_re, w_addr, w_wdata, output w_rdata, w_rvalid);
endinterface

// File: rtl/m_clint.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip registers,
// registered timer-interrupt compare and a single-cycle-latency register read port.
module m_clint #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_time_en,
  m_clint_if.slave           bus,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [13:0]   CMP_BASE_W = 14'h1000;
  localparam logic [13:0]   MTIME_LO_W = 14'h2FFE;
  localparam logic [13:0]   MTIME_HI_W = 14'h2FFF;

  logic [13:0] word;
  logic        unused_addr_lsbs;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [31:0]   rd_val;
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic [63:0]   cmp_arr [N_HARTS];
  logic [N_HARTS-1:0] msip_vec;
  logic [N_HARTS-1:0] mtip_vec;

  assign word             = bus.w_addr[15:2];
  assign unused_addr_lsbs = ^bus.w_addr[1:0];
  assign wr_mtime_lo      = bus.w_we && (word == MTIME_LO_W);
  assign wr_mtime_hi      = bus.w_we && (word == MTIME_HI_W);

  // Increment first, then let a software write overwrite only the half it targets.
  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    tick    = 1'b0;
    if (w_time_en) begin
      if (presc_q == PRESC_MAX) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr_mtime_lo) mtime_d[31:0]  = bus.w_wdata;
    if (wr_mtime_hi) mtime_d[63:32] = bus.w_wdata;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_hart
      logic        sel_msip, sel_cmp_lo, sel_cmp_hi;
      logic [63:0] cmp_q;
      logic        msip_q;
      logic        mtip_q;

      assign sel_msip   = (word == 14'(gi));
      assign sel_cmp_lo = (word == CMP_BASE_W + 14'(2 * gi));
      assign sel_cmp_hi = (word == CMP_BASE_W + 14'(2 * gi + 1));

      // mtip uses the pre-edge mtime/mtimecmp, so it lags register changes by one cycle.
      always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
          cmp_q  <= '1;
          msip_q <= 1'b0;
          mtip_q <= 1'b0;
        end else begin
          if (bus.w_we && sel_cmp_lo) cmp_q[31:0]  <= bus.w_wdata;
          if (bus.w_we && sel_cmp_hi) cmp_q[63:32] <= bus.w_wdata;
          if (bus.w_we && sel_msip)   msip_q       <= bus.w_wdata[0];
          mtip_q <= (mtime_q >= cmp_q);
        end
      end

      assign cmp_arr[gi]  = cmp_q;
      assign msip_vec[gi] = msip_q;
      assign mtip_vec[gi] = mtip_q;
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    if (word == MTIME_LO_W) rd_val = mtime_q[31:0];
    if (word == MTIME_HI_W) rd_val = mtime_q[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      if (word == 14'(h))                     rd_val = {31'd0, msip_vec[h]};
      if (word == CMP_BASE_W + 14'(2 * h))     rd_val = cmp_arr[h][31:0];
      if (word == CMP_BASE_W + 14'(2 * h + 1)) rd_val = cmp_arr[h][63:32];
    end
  end

  // Read data comes from current register values, so a same-cycle write is not visible.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.w_re;
      if (bus.w_re) rdata_q <= rd_val;
    end
  end

  assign bus.w_rdata  = rdata_q;
  assign bus.w_rvalid = rvalid_q;
  assign w_mtime      = mtime_q;
  assign w_mtip       = mtip_vec;
  assign w_msip       = msip_vec;
endmodule

// File: tb/tb_m_clint.sv
// Randomised scoreboard bench for m_clint: a two-hart instance checked every cycle
// against an arithmetic reference model, plus a four-cycle-prescaler instance.
module tb_m_clint;
  localparam int NH_A  = 2;
  localparam int DIV_A = 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ten_a = 1'b0;
  logic ten_b = 1'b0;
  logic [63:0] a_mtime, b_mtime;
  logic [NH_A-1:0] a_mtip, a_msip;
  logic [0:0] b_mtip, b_msip;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  exp_t exp_q[$];

  logic [63:0]     m_mtime;
  int              m_presc;
  logic [63:0]     m_cmp [NH_A];
  logic [NH_A-1:0] m_msip;
  logic [NH_A-1:0] m_mtip;

  m_clint_if a_if ();
  m_clint_if b_if ();

  m_clint #(.N_HARTS(NH_A), .TICK_DIV(DIV_A)) u_dut_a (
    .CLK(clk), .RST_X(rst_n), .w_time_en(ten_a), .bus(a_if),
    .w_mtime(a_mtime), .w_mtip(a_mtip), .w_msip(a_msip)
  );

  m_clint #(.N_HARTS(1), .TICK_DIV(4)) u_dut_b (
    .CLK(clk), .RST_X(rst_n), .w_time_en(ten_b), .bus(b_if),
    .w_mtime(b_mtime), .w_mtip(b_mtip), .w_msip(b_msip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mtime = '0;
    m_presc = 0;
    for (int h = 0; h < NH_A; h++) m_cmp[h] = '1;
    m_msip = '0;
    m_mtip = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    logic [15:0] a;
    a = addr & 16'hFFFC;
    if (a == 16'hBFF8) return m_mtime[31:0];
    if (a == 16'hBFFC) return m_mtime[63:32];
    for (int h = 0; h < NH_A; h++) begin
      if (a == 16'(4 * h))              return {31'd0, m_msip[h]};
      if (a == 16'h4000 + 16'(8 * h))   return m_cmp[h][31:0];
      if (a == 16'h4004 + 16'(8 * h))   return m_cmp[h][63:32];
    end
    return 32'd0;
  endfunction

  // One bus cycle on instance A; the model advances across the same rising edge.
  task automatic step(input logic we, input logic re, input logic [15:0] addr,
                      input logic [31:0] wd, input logic ten);
    logic [63:0]     nx_mtime;
    int              nx_presc;
    logic [63:0]     nx_cmp [NH_A];
    logic [NH_A-1:0] nx_msip, nx_mtip;
    logic [15:0]     a;
    @(negedge clk);
    a_if.w_we = we; a_if.w_re = re; a_if.w_addr = addr; a_if.w_wdata = wd; ten_a = ten;
    if (re) exp_q.push_back('{cyc + 1, model_read(addr)});
    for (int h = 0; h < NH_A; h++) nx_mtip[h] = (m_mtime >= m_cmp[h]);
    nx_mtime = m_mtime;
    nx_presc = m_presc;
    if (ten) begin
      if (m_presc == DIV_A - 1) begin
        nx_mtime = m_mtime + 64'd1;
        nx_presc = 0;
      end else begin
        nx_presc = m_presc + 1;
      end
    end
    nx_cmp = m_cmp;
    nx_msip = m_msip;
    if (we) begin
      a = addr & 16'hFFFC;
      if (a == 16'hBFF8) nx_mtime[31:0]  = wd;
      if (a == 16'hBFFC) nx_mtime[63:32] = wd;
      for (int h = 0; h < NH_A; h++) begin
        if (a == 16'(4 * h))            nx_msip[h]         = wd[0];
        if (a == 16'h4000 + 16'(8 * h)) nx_cmp[h][31:0]   = wd;
        if (a == 16'h4004 + 16'(8 * h)) nx_cmp[h][63:32]  = wd;
      end
    end
    @(posedge clk);
    m_mtime = nx_mtime; m_presc = nx_presc; m_cmp = nx_cmp; m_msip = nx_msip; m_mtip = nx_mtip;
  endtask

  task automatic idle(input int n, input logic ten);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0, ten);
  endtask

  // Monitor: state outputs every cycle, read responses popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   due;
      exp_t e;
      check("mtime", a_mtime, m_mtime);
      check("msip", 64'(a_msip), 64'(m_msip));
      check("mtip", 64'(a_mtip), 64'(m_mtip));
      due = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      check("rvalid", 64'(a_if.w_rvalid), 64'(due));
      if (due) begin
        e = exp_q.pop_front();
        if (a_if.w_rvalid) begin
          check("rdata", 64'(a_if.w_rdata), 64'(e.data));
          $display("read resp cycle %0d data 0x%08h", cyc, a_if.w_rdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr_tab [11];
    addr_tab = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h1234};
    a_if.w_we = 0; a_if.w_re = 0; a_if.w_addr = 0; a_if.w_wdata = 0;
    b_if.w_we = 0; b_if.w_re = 0; b_if.w_addr = 0; b_if.w_wdata = 0;
    model_reset();
    #1;
    check("rst_mtime", a_mtime, 64'd0);
    check("rst_msip", 64'(a_msip), 64'd0);
    check("rst_mtip", 64'(a_mtip), 64'd0);
    check("rst_rvalid", 64'(a_if.w_rvalid), 64'd0);
    check("rst_rdata", 64'(a_if.w_rdata), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset values of mtimecmp and mtime
    step(0, 1, 16'h4000, 0, 0);
    step(0, 1, 16'h4004, 0, 0);
    step(0, 1, 16'h400C, 0, 0);
    step(0, 1, 16'hBFF8, 0, 0);
    // msip decode: only bit0 stored, out-of-range hart and holes read 0
    step(1, 0, 16'h0004, 32'h3, 0);
    step(0, 1, 16'h0004, 0, 0);
    check("msip_pattern", 64'(a_msip), 64'b10);
    step(0, 1, 16'h0008, 0, 0);
    step(0, 1, 16'h1234, 0, 0);
    step(1, 0, 16'h0008, 32'h1, 0);
    step(0, 1, 16'h0008, 0, 0);
    // Same-cycle write and read returns pre-write value
    step(1, 1, 16'h0000, 32'h1, 0);
    idle(1, 0);
    // Low-word carry into high word
    step(1, 0, 16'hBFF8, 32'hFFFF_FFFF, 0);
    step(1, 0, 16'hBFFC, 32'h0, 0);
    idle(1, 1);
    step(0, 1, 16'hBFFC, 0, 0);
    step(0, 1, 16'hBFF8, 0, 0);
    // 64-bit wrap and write-vs-increment precedence
    step(1, 0, 16'hBFF8, 32'hFFFF_FFFF, 0);
    step(1, 0, 16'hBFFC, 32'hFFFF_FFFF, 0);
    idle(2, 1);
    step(1, 0, 16'hBFF8, 32'hFFFF_FFFF, 1);
    step(1, 0, 16'hBFFD, 32'h0000_0007, 1);
    idle(1, 1);
    // Timer interrupt on hart 1 rising at mtime=5, then cleared by raising mtimecmp
    step(1, 0, 16'hBFF8, 32'h0, 0);
    step(1, 0, 16'hBFFC, 32'h0, 0);
    step(1, 0, 16'h4008, 32'h5, 0);
    step(1, 0, 16'h400C, 32'h0, 0);
    idle(8, 1);
    check("mtip1_set", 64'(a_mtip), 64'b10);
    step(1, 0, 16'h400C, 32'h1, 1);
    idle(2, 1);
    check("mtip1_clr", 64'(a_mtip), 64'b00);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ad;
      logic        we, re, ten;
      ad  = addr_tab[$urandom_range(0, 10)] | 16'($urandom_range(0, 3));
      we  = ($urandom_range(0, 99) < 40);
      re  = ($urandom_range(0, 99) < 40);
      ten = ($urandom_range(0, 99) < 70);
      step(we, re, ad, $urandom, ten);
    end
    idle(2, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Reset between edges while a read response is pending
    step(1, 0, 16'hBFF8, 32'd100, 0);
    step(1, 0, 16'hBFFC, 32'd0, 0);
    step(1, 0, 16'h0000, 32'd1, 0);
    step(1, 0, 16'h4000, 32'd0, 0);
    step(1, 0, 16'h4004, 32'd0, 0);
    idle(1, 0);
    step(0, 1, 16'hBFF8, 0, 0);
    #1;
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 64'(a_if.w_rvalid), 64'd0);
    check("midrst_rdata", 64'(a_if.w_rdata), 64'd0);
    check("midrst_mtime", a_mtime, 64'd0);
    check("midrst_msip", 64'(a_msip), 64'd0);
    check("midrst_mtip", 64'(a_mtip), 64'd0);
    exp_q.delete();
    model_reset();
    a_if.w_we = 0; a_if.w_re = 0; ten_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(0, 1, 16'h4000, 0, 0);
    idle(2, 0);

    // Prescaler of four on instance B
    check("b_start", b_mtime, 64'd0);
    @(negedge clk);
    ten_b = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check("b_presc", b_mtime, 64'(i / 4));
    end
    ten_b = 1'b0;
    check("b_after40", b_mtime, 64'd10);
    repeat (20) @(negedge clk);
    check("b_frozen", b_mtime, 64'd10);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
